// File: rtl/du_fw_loader.sv
// du_fw_loader: debug-unit firmware loader (RX FIFO -> IMEM, ACK/NAK on TX).
// Optional inter-byte timeout: define DU_LOADER_TIMEOUT_EN.
module du_fw_loader #(
  parameter int NB_INSTRUCTION = 32,
  parameter int NB_UART_DATA   = 8,
  parameter int NB_IMEM_ADDR   = 10,
  parameter int MAX_WORDS      = 256
`ifdef DU_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_rx_done,
  input  logic [NB_UART_DATA-1:0]   i_rx_data,
  input  logic                      i_tx_full,
  output logic                      o_rd,
  output logic                      o_wr,
  output logic [NB_UART_DATA-1:0]   o_wdata,
  output logic                      o_tx_start,
  output logic                      o_imem_we,
  output logic [NB_IMEM_ADDR-1:0]   o_imem_waddr,
  output logic [NB_INSTRUCTION-1:0] o_imem_wdata,
  output logic                      o_done
);

  localparam int BPW    = NB_INSTRUCTION / NB_UART_DATA;
  localparam int IDXW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NB_CNT = 2 * NB_UART_DATA;

  localparam logic [NB_UART_DATA-1:0] ACK = NB_UART_DATA'(8'h05);
  localparam logic [NB_UART_DATA-1:0] NAK = NB_UART_DATA'(8'h15);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);
  localparam logic [NB_IMEM_ADDR-1:0] ADDR_STEP = NB_IMEM_ADDR'(BPW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_RESP,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [NB_CNT-1:0]         cnt_q;
  logic [NB_IMEM_ADDR-1:0]   addr_q;
  logic [IDXW-1:0]           idx_q;
  logic [NB_UART_DATA-1:0]   sum_q;
  logic [NB_INSTRUCTION-1:0] word_q;
  logic [NB_UART_DATA-1:0]   resp_q;
  logic                      imem_we_q;
  logic [NB_IMEM_ADDR-1:0]   imem_waddr_q;
  logic [NB_INSTRUCTION-1:0] imem_wdata_q;
  logic                      done_q;

`ifdef DU_LOADER_TIMEOUT_EN
  localparam int TMOW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT_CYCLES - 1);
  logic [TMOW-1:0] tmo_q;
`endif

  logic                      rx_en;
  logic                      pop;
  logic                      push;
  logic [NB_INSTRUCTION-1:0] word_d;
  logic [NB_UART_DATA-1:0]   sum_d;
  logic [NB_CNT-1:0]         len_d;

  // RX pop / TX push strobes and next-value helpers for the byte path
  always_comb begin
    rx_en  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
             (state_q == S_DATA)   || (state_q == S_CHK);
    pop    = rx_en && i_rx_done;
    push   = (state_q == S_RESP) && !i_tx_full && i_start;
    word_d = word_q;
    word_d[int'(idx_q)*NB_UART_DATA +: NB_UART_DATA] = i_rx_data;
    sum_d  = sum_q + i_rx_data;
    len_d  = {i_rx_data, cnt_q[NB_UART_DATA-1:0]};
  end

  assign o_rd         = pop;
  assign o_wr         = push;
  assign o_tx_start   = push;
  assign o_wdata      = push ? resp_q : '0;
  assign o_imem_we    = imem_we_q;
  assign o_imem_waddr = imem_waddr_q;
  assign o_imem_wdata = imem_wdata_q;
  assign o_done       = done_q;

  // Frame FSM: length, data assembly, checksum, response, completion
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      word_q       <= '0;
      resp_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
`ifdef DU_LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (pop) begin
            cnt_q   <= {{NB_UART_DATA{1'b0}}, i_rx_data};
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (pop) begin
            cnt_q <= len_d;
            idx_q <= '0;
            if (len_d > NB_CNT'(MAX_WORDS)) begin
              resp_q  <= NAK;
              state_q <= S_RESP;
            end else if (len_d == '0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (pop) begin
            word_q <= word_d;
            sum_q  <= sum_d;
            idx_q  <= idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
              imem_we_q    <= 1'b1;
              imem_waddr_q <= addr_q;
              imem_wdata_q <= word_d;
              addr_q       <= addr_q + ADDR_STEP;
              cnt_q        <= cnt_q - NB_CNT'(1);
              if (cnt_q == NB_CNT'(1)) begin
                state_q <= S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          if (pop) begin
            resp_q  <= (sum_d == '0) ? ACK : NAK;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (push) begin
            if (resp_q == ACK) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q  <= '0;
              sum_q   <= '0;
              idx_q   <= '0;
              state_q <= S_LEN_LO;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
`ifdef DU_LOADER_TIMEOUT_EN
      if (rx_en && !pop) begin
        if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          resp_q  <= NAK;
          state_q <= S_RESP;
        end else begin
          tmo_q <= tmo_q + TMOW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
`endif
      if (!i_start && state_q != S_DONE) begin
        state_q <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_du_fw_loader.sv
// tb_du_fw_loader: table-driven frames plus hand sequences, scoreboarded
// IMEM writes and TX bytes against an RX FIFO model.
module tb_du_fw_loader;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_tx_full;
  logic        o_rd;
  logic        o_wr;
  logic [7:0]  o_wdata;
  logic        o_tx_start;
  logic        o_imem_we;
  logic [9:0]  o_imem_waddr;
  logic [31:0] o_imem_wdata;
  logic        o_done;

  always #5 clk = ~clk;

  du_fw_loader #(
    .NB_INSTRUCTION(32),
    .NB_UART_DATA(8),
    .NB_IMEM_ADDR(10),
    .MAX_WORDS(MAXW)
`ifdef DU_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data),
    .i_tx_full(i_tx_full),
    .o_rd(o_rd),
    .o_wr(o_wr),
    .o_wdata(o_wdata),
    .o_tx_start(o_tx_start),
    .o_imem_we(o_imem_we),
    .o_imem_waddr(o_imem_waddr),
    .o_imem_wdata(o_imem_wdata),
    .o_done(o_done)
  );

  typedef struct packed {
    logic [15:0] n;
    logic [63:0] d;
    logic [7:0]  chk;
    logic        spaced;
    logic        ack;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_writes = 0;
  int n_done = 0;
  int n_tx = 0;
  bit spaced = 0;

  logic [7:0]  rx_q[$];
  logic [41:0] wq[$];
  logic [7:0]  txq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // RX FIFO model, first-word fall-through
  initial begin
    bit p;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      p = o_rd;
      @(posedge clk);
      #1;
      if (p && rx_q.size() != 0) void'(rx_q.pop_front());
      if (spaced && $urandom_range(0, 2) == 0) i_rx_done = 1'b0;
      else i_rx_done = (rx_q.size() != 0);
      i_rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  // Output monitor: scoreboard pops on every IMEM write and TX push
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_imem_we) begin
        n_writes++;
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL imem_unexpected actual=%0h_%0h required=none",
                   o_imem_waddr, o_imem_wdata);
        end else begin
          chk("imem_write", {o_imem_waddr, o_imem_wdata}, wq.pop_front());
        end
      end
      if (o_wr) begin
        n_tx++;
        chk("tx_start_eq_wr", o_tx_start, 1'b1);
        if (txq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=none", o_wdata);
        end else begin
          chk("tx_byte", o_wdata, txq.pop_front());
        end
      end
      if (o_done) n_done++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_frame(input vec_t v);
    rx_q.push_back(v.n[7:0]);
    rx_q.push_back(v.n[15:8]);
    if (v.n <= 16'(MAXW)) begin
      for (int i = 0; i < int'(v.n); i++) begin
        wq.push_back({10'(i * 4), v.d[32*i +: 32]});
        for (int k = 0; k < 4; k++) rx_q.push_back(v.d[32*i + 8*k +: 8]);
      end
      rx_q.push_back(v.chk);
    end
    txq.push_back(v.ack ? 8'h05 : 8'h15);
  endtask

  task automatic wait_done(input string nm, input int target);
    int c;
    c = 0;
    while (n_done < target && c < 2000) begin
      tick(1);
      c++;
    end
    if (n_done < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", nm, n_done, target);
    end
  endtask

  task automatic wait_tx(input string nm, input int target);
    int c;
    c = 0;
    while (n_tx < target && c < 2000) begin
      tick(1);
      c++;
    end
    if (n_tx < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", nm, n_tx, target);
    end
  endtask

  task automatic wait_rx_empty();
    int c;
    c = 0;
    while (rx_q.size() != 0 && c < 2000) begin
      tick(1);
      c++;
    end
    chk("rx_drained", rx_q.size(), 0);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_wq"}, wq.size(), 0);
    chk({nm, "_txq"}, txq.size(), 0);
    chk({nm, "_rxq"}, rx_q.size(), 0);
  endtask

  vec_t vecs[5];
  vec_t good;
  vec_t bad;

  initial begin
    int d0, w0, t0, c;
    vecs[0] = '{n: 16'd1, d: 64'h13, chk: 8'hED, spaced: 1'b0, ack: 1'b1};
    vecs[1] = '{n: 16'd2, d: 64'h1A1A1A1A_00500093, chk: 8'hB5,
                spaced: 1'b1, ack: 1'b1};
    vecs[2] = '{n: 16'd0, d: 64'h0, chk: 8'h00, spaced: 1'b0, ack: 1'b1};
    vecs[3] = '{n: 16'h0101, d: 64'h0, chk: 8'h00, spaced: 1'b0, ack: 1'b0};
    vecs[4] = '{n: 16'd1, d: 64'h13, chk: 8'hEE, spaced: 1'b0, ack: 1'b0};
    good = vecs[0];
    bad  = vecs[4];

    i_rst = 1'b1;
    i_start = 1'b0;
    i_tx_full = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_rd", o_rd, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_we", o_imem_we, 0);
    chk("rst_waddr", o_imem_waddr, 0);
    chk("rst_wdata_imem", o_imem_wdata, 0);
    chk("rst_done", o_done, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      d0 = n_done;
      w0 = n_writes;
      spaced = vecs[i].spaced;
      i_start = 1'b1;
      load_frame(vecs[i]);
      if (vecs[i].ack) wait_done("vec_done", d0 + 1);
      else wait_tx("vec_nak", n_tx + 1);
      i_start = 1'b0;
      tick(3);
      spaced = 1'b0;
      drained($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_done", i), n_done - d0, vecs[i].ack ? 1 : 0);
      chk($sformatf("vec%0d_writes", i), n_writes - w0,
          (vecs[i].n <= 16'(MAXW)) ? vecs[i].n : 0);
    end

    // NAK then retransmit the body without leaving the session
    d0 = n_done;
    i_start = 1'b1;
    load_frame(bad);
    wait_tx("retry_nak", n_tx + 1);
    tick(2);
    chk("retry_no_done", n_done - d0, 0);
    load_frame(good);
    wait_done("retry_done", d0 + 1);
    i_start = 1'b0;
    tick(3);
    drained("retry");

    // TX FIFO full holds the ACK back
    d0 = n_done;
    i_tx_full = 1'b1;
    i_start = 1'b1;
    load_frame(good);
    wait_rx_empty();
    t0 = n_tx;
    tick(10);
    chk("txfull_hold", n_tx - t0, 0);
    chk("txfull_hold_done", n_done - d0, 0);
    i_tx_full = 1'b0;
    wait_done("txfull_done", d0 + 1);
    i_start = 1'b0;
    tick(3);
    chk("txfull_one_push", n_tx - t0, 1);
    drained("txfull");

    // Abort mid-DATA, then a clean frame proves we are back in IDLE
    d0 = n_done;
    w0 = n_writes;
    t0 = n_tx;
    i_start = 1'b1;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h13);
    rx_q.push_back(8'h00);
    wait_rx_empty();
    tick(1);
    i_start = 1'b0;
    tick(5);
    chk("abort_no_tx", n_tx - t0, 0);
    chk("abort_no_write", n_writes - w0, 0);
    chk("abort_no_done", n_done - d0, 0);
    i_start = 1'b1;
    load_frame(good);
    wait_done("abort_after", d0 + 1);
    i_start = 1'b0;
    tick(3);
    drained("abort");

`ifdef DU_LOADER_TIMEOUT_EN
    // Stall after two data bytes: timeout NAK, restart at LEN_LO, addr 0
    d0 = n_done;
    t0 = n_tx;
    i_start = 1'b1;
    txq.push_back(8'h15);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h13);
    rx_q.push_back(8'h00);
    wait_rx_empty();
    c = 0;
    while (n_tx == t0 && c < 300) begin
      tick(1);
      c++;
    end
    chk("tmo_nak_seen", n_tx - t0, 1);
    chk("tmo_window", (c >= 99 && c <= 103) ? 1 : 0, 1);
    load_frame(good);
    wait_done("tmo_after", d0 + 1);
    i_start = 1'b0;
    tick(3);
    drained("tmo");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/du_fw_loader.md
# du_fw_loader

Firmware loader for the debug unit. It runs while the debug-unit master asserts its load request. It pulls the firmware frame body from the UART RX FIFO, assembles little-endian 32-bit instructions, writes them sequentially into IMEM, validates a checksum, answers the host with ACK/NAK through the UART TX FIFO, and reports completion back to the master. It sits between the UART FIFOs and the IMEM write port, directly downstream of the master's load request.

## Interface

- NB_INSTRUCTION, 32, IMEM word width
- NB_UART_DATA, 8, UART byte width
- NB_IMEM_ADDR, 10, IMEM byte-address width
- MAX_WORDS, 256, largest accepted word count
- TIMEOUT_CYCLES, 50_000_000, inter-byte timeout (only with the macro below)

Ports:

- clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  level load request from master; low aborts any frame
- i_rx_done  in  1  RX FIFO has a byte (first-word fall-through)
- i_rx_data  in  NB_UART_DATA  RX FIFO head byte
- i_tx_full  in  1  TX FIFO full
- o_rd  out  1  RX FIFO pop
- o_wr  out  1  TX FIFO push
- o_wdata  out  NB_UART_DATA  TX byte
- o_tx_start  out  1  TX kick, identical to o_wr
- o_imem_we  out  1  IMEM write strobe
- o_imem_waddr  out  NB_IMEM_ADDR  IMEM byte address
- o_imem_wdata  out  NB_INSTRUCTION  IMEM write word
- o_done  out  1  one-cycle load-complete pulse

## Operation

Frame body (the SOT byte is consumed by the master): N_LO, N_HI (16-bit word count), 4·N data bytes, CHK. Validity rule: the 8-bit sum of all data bytes plus CHK must equal 0x00 mod 256.

States:

- IDLE: on i_start, clear the address, byte index and sum, then go to LEN_LO.
- LEN_LO / LEN_HI: pop one byte each to form N.
  - In LEN_HI, if N > MAX_WORDS, go to RESP with NAK.
  - In LEN_HI, if N == 0, go to CHK.
  - Otherwise go to DATA.
- DATA: pop a byte whenever one is available.
  - Byte k of a word goes into bits [8k+7:8k], so the first byte is the LSB.
  - The byte is added to the sum.
  - On the 4th byte, write the word, add 4 to the address and decrement the remaining count.
  - After the last word, go to CHK.
- CHK: pop CHK. If sum + CHK == 0, go to RESP with ACK (0x05); otherwise go to RESP with NAK (0x15).
- RESP: wait while i_tx_full. When not full, push the response byte for exactly one cycle.
  - After ACK, go to DONE.
  - After NAK, go to LEN_LO with address and sum cleared; the host retransmits the body without SOT.
- DONE: o_done=1 for one cycle, then IDLE.

Popping rule: o_rd = i_rx_done AND state ∈ {LEN_LO, LEN_HI, DATA, CHK}. This gives at most one pop per cycle, and data is sampled in the same cycle as the pop.

Boundaries:

- **i_start low** in any state except DONE: return to IDLE with no response. Already written IMEM words remain.
- **Address wrap:** the address wraps modulo 2^NB_IMEM_ADDR. MAX_WORDS·4 ≤ 2^NB_IMEM_ADDR is required by configuration.
- **Reset mid-frame:** everything clears to IDLE, including any pending IMEM write.
- **NAK retry:** repeats with no limit.

## Timing

- Reset values: all outputs 0, state IDLE, address 0.
- o_rd and TX outputs are combinational from state and inputs. o_imem_we, o_imem_waddr, o_imem_wdata and o_done are registered.
- IMEM write latency: o_imem_we is high exactly the cycle after the 4th byte is popped. o_imem_waddr is the pre-increment address.
- Minimum frame time for N words: 2 + 4N + 1 pops, plus 1 RESP cycle, plus 1 DONE cycle.
- o_done rises the cycle after the ACK push, and only once per ACK.

## Configuration

- DU_LOADER_TIMEOUT_EN defined:
  - A counter restarts on every pop while in LEN_LO, LEN_HI, DATA or CHK.
  - Reaching TIMEOUT_CYCLES−1 without a byte sends NAK via RESP and restarts at LEN_LO with address cleared.
- Undefined: no counter; states wait for bytes indefinitely.

## Test plan

- N=1, bytes 13 00 00 00, CHK=ED: one write of 0x00000013 @0x000, ACK 0x05 pushed, o_done pulse, back in IDLE.
- N=2, words 0x00500093 and 0x1A1A1A1A with correct CHK, RX bytes spaced randomly: writes @0x000 then @0x004, ACK, o_done.
- N=1 with bad CHK (EE): NAK 0x15, no o_done. Then resend the valid body: rewrite @0x000, ACK, o_done.
- N=MAX_WORDS+1 (0x0101): NAK right after LEN_HI, no IMEM write.
- i_tx_full held high for 10 cycles at RESP: no o_wr until it drops, then exactly one 0x05 push. Also check i_start dropped mid-DATA → IDLE with no TX.
- With DU_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall after 2 data bytes → NAK at cycle 100, state LEN_LO, address 0.
